// File: rtl/calc_pkg.sv
// calc_pkg: shared types and sizing for the calculator arithmetic sequencer.
`default_nettype none

package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDSUB = 2'd1,
    ITER   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: one combinational step of shift-add multiply or restoring divide.
`default_nettype none

module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  op_t                mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    // mul: upper half accumulates, lower half holds the remaining multiplier bits
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // div: upper half is the partial remainder, lower half dividend then quotient
    shifted = {acc, 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
    if (mode == OP_DIV) begin
      if (trial[WIDTH]) begin
        acc_next = shifted[2*WIDTH-1:0];
      end else begin
        acc_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// calc_sequencer: sequences add/sub (one cycle) and mul/div (WIDTH iterations)
// with busy/done handshaking and registered result and status flags.
`default_nettype none

module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 neg,
  output logic                 div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               complete;
  logic [2*WIDTH-1:0] addsub_res;
  logic               sub_neg;
  logic [WIDTH-1:0]   iter_operand;

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc),
    .operand  (iter_operand),
    .mode     (op_q),
    .acc_next (acc_nxt)
  );

  assign busy         = (state != IDLE);
  assign iter_operand = (op_q == OP_DIV) ? b_q : a_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_ADD, OP_SUB: state_nxt = ADDSUB;
            OP_MUL:         state_nxt = ITER;
            default:        state_nxt = (operand_b == '0) ? FINISH : ITER;
          endcase
        end
      end
      ADDSUB: begin
        state_nxt = IDLE;
        complete  = 1'b1;
      end
      ITER: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        complete  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sub_neg    = 1'b0;
    addsub_res = '0;
    if (op_q == OP_SUB) begin
      sub_neg    = (a_q < b_q);
      addsub_res = {{WIDTH{1'b0}}, (sub_neg ? (b_q - a_q) : (a_q - b_q))};
    end else begin
      addsub_res = {{(WIDTH-1){1'b0}}, ({1'b0, a_q} + {1'b0, b_q})};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      result   <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= complete;
      case (state)
        IDLE: begin
          // Operands are captured only here, so inputs moving while busy are harmless
          if (start) begin
            op_q <= op_t'(op);
            a_q  <= operand_a;
            b_q  <= operand_b;
            acc  <= (op_t'(op) == OP_MUL) ? {{WIDTH{1'b0}}, operand_b}
                                          : {{WIDTH{1'b0}}, operand_a};
            cnt  <= CNT_W'(WIDTH);
          end
        end
        ADDSUB: begin
          result   <= addsub_res;
          neg      <= sub_neg;
          div_zero <= 1'b0;
        end
        ITER: begin
          if (cnt == '0) begin
            result   <= acc;
            neg      <= 1'b0;
            div_zero <= 1'b0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          result   <= '0;
          neg      <= 1'b0;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scoreboard bench for calc_sequencer.
`default_nettype none

module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W = CALC_WIDTH;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = 2'd0;
  logic [W-1:0]   operand_a = '0;
  logic [W-1:0]   operand_b = '0;
  logic           busy, done, neg, div_zero;
  logic [2*W-1:0] result;

  typedef struct {
    logic [2*W-1:0] res;
    logic           neg;
    logic           dz;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  calc_sequencer #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .neg       (neg),
    .div_zero  (div_zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = '0;
    e.neg = 1'b0;
    e.dz  = 1'b0;
    case (o)
      2'd0: e.res = 16'(a) + 16'(b);
      2'd1: begin
        if (a >= b) e.res = 16'(a - b);
        else begin
          e.res = 16'(b - a);
          e.neg = 1'b1;
        end
      end
      2'd2: e.res = 16'(a) * 16'(b);
      default: begin
        if (b == 0) e.dz = 1'b1;
        else e.res = {8'(a % b), 8'(a / b)};
      end
    endcase
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e.res));
      check({tag, "_neg"}, 32'(neg), 32'(e.neg));
      check({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
    end
  endtask

  // Returns the edge index (relative to the start edge) at which done rose, or -1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat);
    int lat;
    sb.push_back(model(o, a, b));
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    op = ~o;
    operand_a = ~a;
    operand_b = ~b;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    pop_check(tag);
    step();
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;

    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    RST = 1'b0;
    step();

    run_op("add_200_100", 2'd0, 8'd200, 8'd100, 1);
    run_op("sub_5_9", 2'd1, 8'd5, 8'd9, 1);
    run_op("sub_9_5", 2'd1, 8'd9, 8'd5, 1);
    run_op("mul_255_255", 2'd2, 8'd255, 8'd255, 9);
    run_op("div_200_7", 2'd3, 8'd200, 8'd7, 9);
    run_op("div_by_zero", 2'd3, 8'd5, 8'd0, 1);
    run_op("div_100_10", 2'd3, 8'd100, 8'd10, 9);
    run_op("mul_13_11", 2'd2, 8'd13, 8'd11, 9);
    run_op("div_255_1", 2'd3, 8'd255, 8'd1, 9);
    run_op("add_255_255", 2'd0, 8'd255, 8'd255, 1);
    run_op("div_3_200", 2'd3, 8'd3, 8'd200, 9);

    // start pulse in the middle of a multiply must be ignored
    sb.push_back(model(2'd2, 8'd3, 8'd4));
    op = 2'd2;
    operand_a = 8'd3;
    operand_b = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    op = 2'd0;
    operand_a = 8'd1;
    operand_b = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int i = 4; i <= 24; i++) begin
      step();
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          pop_check("ignore_busy");
        end
      end
    end
    check("ignore_busy_done_count", 32'(ndone), 32'd1);
    check("ignore_busy_latency", 32'(lat), 32'd9);

    // reset in the middle of a multiply aborts it without a done
    op = 2'd2;
    operand_a = 8'd7;
    operand_b = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    RST = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    RST = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op("post_reset_mul", 2'd2, 8'd7, 8'd9, 9);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
